arb2_stream: RTL and testbench
==============================

ARB2_STREAM -- requirements
Module: arb2_stream

Interface
REQ-001 Parameter: WIDTH, 8, data width of each requester and the output.
REQ-002 Parameter: MAXBURST, 4, max consecutive transfers granted to one requester while the other waits (range 1..15).
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 d0  input  WIDTH  requester 0 data.
REQ-007 v0  input  1  requester 0 valid.
REQ-008 r0  output  1  requester 0 ready.
REQ-009 d1  input  WIDTH  requester 1 data.
REQ-010 v1  input  1  requester 1 valid.
REQ-011 r1  output  1  requester 1 ready.
REQ-012 y  output  WIDTH  registered output data.
REQ-013 yv  output  1  output valid.
REQ-014 yr  input  1  downstream ready.
REQ-015 s  output  1  current mux select: 1 in GRANT1, else 0.

Function
REQ-016 The block SHALL define a transfer on port n as vn&rn, and an output transfer as yv&yr, each sampled at the rising clk edge.
REQ-017 The FSM SHALL have states IDLE, GRANT0 and GRANT1, plus a last-served pointer lp (1 bit) and a burst counter cnt (4 bits).
REQ-018 In IDLE: if v0&v1, go to GRANT(!lp); else if v0 go to GRANT0; else if v1 go to GRANT1; else stay in IDLE; r0=r1=0.
REQ-019 On every entry to GRANTn, lp SHALL be set to n and cnt cleared to 0.
REQ-020 In GRANTn, rn SHALL equal (!yv | yr), and the other ready SHALL be 0; rn is combinational from state, yv and yr only, never from vn.
REQ-021 In GRANTn, cnt_next = cnt + (vn&rn), saturating at MAXBURST; o denotes the other requester.
REQ-022 GRANTn SHALL go to GRANTo when vo & (!vn | cnt_next == MAXBURST); else to IDLE when !vn & !vo; else stay.
REQ-023 A port transfer SHALL load y<=dn and yv<=1 on the same edge, giving one-cycle latency from accept to output.
REQ-024 yv SHALL clear on an output transfer with no simultaneous port transfer; simultaneous output and port transfers SHALL replace y with the new word, keeping yv=1 (full throughput).
REQ-025 While yv&!yr, y and yv SHALL hold unchanged, and no port SHALL be ready.
REQ-026 IDLE-to-grant SHALL cost exactly one cycle with no acceptance; GRANTn-to-GRANTo SHALL be direct, with the new requester ready on the next cycle.
REQ-027 A requester dropping vn mid-grant SHALL cause no data loss or duplication; in-flight y is unaffected by grant changes.
REQ-028 MAXBURST=1 SHALL yield strict alternation when both requesters are continuously valid.

Reset
REQ-029 On reset: state=IDLE, lp=1, cnt=0, y=0, yv=0, r0=r1=0, s=0; a held output word SHALL be discarded.
REQ-030 Reset SHALL take priority over all transitions, including on a cycle that is transferring.

Verification
REQ-031 Reset, then v0=1, d0=0x11.. (incrementing), yr=1 -> cycle 1 IDLE->GRANT0, r0=1 from cycle 2, y=0x11 with yv=1 at cycle 3, then one word per cycle.
REQ-032 v0=v1=1 continuously, yr=1, MAXBURST=4 -> output sequence is 4 words from d0, 4 from d1, repeating, with no bubble at switches.
REQ-033 Grant held with yv=1 and yr=0 for 5 cycles -> y stable, r0=r1=0, cnt unchanged; yr=1 resumes with no loss.
REQ-034 In GRANT1, v1 drops while v0=1 -> next cycle GRANT0, s=0, with no duplicated or lost word.
REQ-035 Reset asserted while yv=1 and in GRANT1 -> next cycle yv=0, y=0, state IDLE; a subsequent v0&v1 grants requester 0 first (lp=1).
REQ-036 MAXBURST=1, both requesters valid, yr toggling 1/0 -> strict 0,1,0,1 ordering of output words.

Source files
------------

// File: rtl/arb2_stream.sv
// ---------------------------------------------------------------------------
// arb2_stream
// Two-input valid/ready stream arbiter with a registered output stage.
// Requesters are served in bursts of up to MAXBURST words while the other
// requester waits. A last-served pointer decides who wins when both raise
// valid together from IDLE.
//
// Ports
//   clk    rising-edge clock for all state
//   reset  synchronous, active-high reset
//   d0/v0  requester 0 data / valid;   r0 requester 0 ready
//   d1/v1  requester 1 data / valid;   r1 requester 1 ready
//   y/yv   registered output data / output valid
//   yr     downstream ready
//   s      current mux select (1 while requester 1 holds the grant)
// ---------------------------------------------------------------------------
module arb2_stream #(
    parameter int WIDTH    = 8,
    parameter int MAXBURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d0,
    input  logic             v0,
    output logic             r0,
    input  logic [WIDTH-1:0] d1,
    input  logic             v1,
    output logic             r1,
    output logic [WIDTH-1:0] y,
    output logic             yv,
    input  logic             yr,
    output logic             s
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] MB = 4'(MAXBURST);

    state_t     state, state_next;
    logic       lp, lp_next;
    logic [3:0] cnt, cnt_d, burst;
    logic       out_free;
    logic       t0, t1;
    logic       cur, vn, vo, tn;

    // The output register can take a new word when it is empty or being
    // drained this cycle. Ready depends only on state, yv and yr so there is
    // no combinational path from a requester's valid to its own ready.
    always_comb begin
        out_free = !yv || yr;
        r0       = (state == GRANT0) && out_free;
        r1       = (state == GRANT1) && out_free;
        s        = (state == GRANT1);
        t0       = v0 && r0;
        t1       = v1 && r1;
    end

    // Next-state logic. The two grant states are symmetric, so they share one
    // branch expressed in terms of "own" (n) and "other" (o) requester.
    always_comb begin
        state_next = state;
        lp_next    = lp;
        cnt_d      = cnt;
        cur        = (state == GRANT1);
        vn         = cur ? v1 : v0;
        vo         = cur ? v0 : v1;
        tn         = cur ? t1 : t0;
        burst      = (tn && (cnt != MB)) ? cnt + 4'd1 : cnt;

        case (state)
            IDLE: begin
                if (v0 && v1) begin
                    state_next = lp ? GRANT0 : GRANT1;
                    lp_next    = !lp;
                    cnt_d      = 4'd0;
                end else if (v0) begin
                    state_next = GRANT0;
                    lp_next    = 1'b0;
                    cnt_d      = 4'd0;
                end else if (v1) begin
                    state_next = GRANT1;
                    lp_next    = 1'b1;
                    cnt_d      = 4'd0;
                end
            end
            GRANT0, GRANT1: begin
                if (vo && (!vn || (burst == MB))) begin
                    state_next = cur ? GRANT0 : GRANT1;
                    lp_next    = !cur;
                    cnt_d      = 4'd0;
                end else if (!vn && !vo) begin
                    state_next = IDLE;
                    cnt_d      = burst;
                end else begin
                    cnt_d      = burst;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state register. lp resets to 1 so requester 0 wins the first
    // simultaneous request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lp    <= 1'b1;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            lp    <= lp_next;
            cnt   <= cnt_d;
        end
    end

    // Output register. A port transfer always loads a fresh word, even when
    // the previous one is leaving on the same edge; yv only drops when the
    // word drains with nothing behind it. Reset discards any held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            y  <= '0;
            yv <= 1'b0;
        end else if (t0 || t1) begin
            y  <= t1 ? d1 : d0;
            yv <= 1'b1;
        end else if (yv && yr) begin
            yv <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb2_stream.sv
// ---------------------------------------------------------------------------
// tb_arb2_stream
// Directed bench for arb2_stream. Instance "dut" uses MAXBURST=4, instance
// "dut1" uses MAXBURST=1 for the strict alternation case. A table of vectors
// walks a single-requester stream, a downstream stall and a grant handover;
// hand-written sequences cover bursts, reset mid-transfer and alternation.
// ---------------------------------------------------------------------------
module tb_arb2_stream;

    logic       clk;
    logic       reset;
    logic [7:0] d0, d1, y;
    logic       v0, v1, r0, r1, yv, yr, s;
    logic [7:0] d0b, d1b, yb;
    logic       v0b, v1b, r0b, r1b, yvb, yrb, sb;

    int checks;
    int errors;

    arb2_stream #(.WIDTH(8), .MAXBURST(4)) dut (
        .clk(clk), .reset(reset),
        .d0(d0), .v0(v0), .r0(r0),
        .d1(d1), .v1(v1), .r1(r1),
        .y(y), .yv(yv), .yr(yr), .s(s)
    );

    arb2_stream #(.WIDTH(8), .MAXBURST(1)) dut1 (
        .clk(clk), .reset(reset),
        .d0(d0b), .v0(v0b), .r0(r0b),
        .d1(d1b), .v1(v1b), .r1(r1b),
        .y(yb), .yv(yvb), .yr(yrb), .s(sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       yr;
        logic       r0;
        logic       r1;
        logic       s;
        logic       yv;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[$];

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one table row onto the MAXBURST=4 instance.
    task automatic applyStimulus(input vec_t v);
        v0 = v.v0;
        d0 = v.d0;
        v1 = v.v1;
        d1 = v.d1;
        yr = v.yr;
    endtask

    // Reset both instances for two cycles; returns 1 time unit after an edge.
    task automatic doReset();
        reset = 1'b1;
        v0 = 0; v1 = 0; d0 = 0; d1 = 0; yr = 1;
        v0b = 0; v1b = 0; d0b = 0; d1b = 0; yrb = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Fields: v0 d0 v1 d1 yr | r0 r1 s yv y  (outputs seen before the edge)
        vecs.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{1, 8'h11, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{1, 8'h12, 0, 8'h00, 1, 1, 0, 0, 1, 8'h11});
        vecs.push_back('{1, 8'h13, 0, 8'h00, 0, 0, 0, 0, 1, 8'h12});
        vecs.push_back('{1, 8'h13, 0, 8'h00, 0, 0, 0, 0, 1, 8'h12});
        vecs.push_back('{1, 8'h13, 0, 8'h00, 0, 0, 0, 0, 1, 8'h12});
        vecs.push_back('{1, 8'h13, 0, 8'h00, 0, 0, 0, 0, 1, 8'h12});
        vecs.push_back('{1, 8'h13, 0, 8'h00, 0, 0, 0, 0, 1, 8'h12});
        vecs.push_back('{1, 8'h13, 0, 8'h00, 1, 1, 0, 0, 1, 8'h12});
        vecs.push_back('{0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 8'h13});
        vecs.push_back('{0, 8'h00, 1, 8'hA1, 1, 0, 0, 0, 0, 8'h13});
        vecs.push_back('{0, 8'h00, 1, 8'hA1, 1, 0, 1, 1, 0, 8'h13});
        vecs.push_back('{1, 8'h14, 1, 8'hA2, 1, 0, 1, 1, 1, 8'hA1});
        vecs.push_back('{1, 8'h14, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA2});
        vecs.push_back('{1, 8'h14, 0, 8'h00, 1, 1, 0, 0, 0, 8'hA2});
        vecs.push_back('{0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 8'h14});
        vecs.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h14});

        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_r0", i), {15'd0, r0}, {15'd0, vecs[i].r0});
            checkOutput($sformatf("vec%0d_r1", i), {15'd0, r1}, {15'd0, vecs[i].r1});
            checkOutput($sformatf("vec%0d_s", i),  {15'd0, s},  {15'd0, vecs[i].s});
            checkOutput($sformatf("vec%0d_yv", i), {15'd0, yv}, {15'd0, vecs[i].yv});
            checkOutput($sformatf("vec%0d_y", i),  {8'd0, y},   {8'd0, vecs[i].y});
            @(posedge clk);
            #1;
        end

        // Both requesters always valid: bursts of four, no output bubble.
        begin
            logic [7:0] got[$];
            int         first_idx, last_idx;
            int         i0, i1;
            logic       take0, take1;
            doReset();
            i0 = 0; i1 = 0; first_idx = -1; last_idx = -1;
            v0 = 1; v1 = 1; yr = 1;
            for (int cyc = 0; cyc < 60 && got.size() < 16; cyc++) begin
                d0 = 8'(i0);
                d1 = 8'(8'h80 + i1);
                #1;
                take0 = r0;
                take1 = r1;
                if (yv && yr) begin
                    got.push_back(y);
                    if (first_idx < 0) first_idx = cyc;
                    last_idx = cyc;
                end
                @(posedge clk);
                #1;
                if (take0) i0++;
                if (take1) i1++;
            end
            checkOutput("burst_count", 16'(got.size()), 16'd16);
            foreach (got[k]) begin
                int grp;
                logic [7:0] exp;
                grp = k / 4;
                exp = (grp % 2 == 0) ? 8'((grp / 2) * 4 + k % 4)
                                     : 8'(8'h80 + (grp / 2) * 4 + k % 4);
                checkOutput($sformatf("burst_word%0d", k), {8'd0, got[k]}, {8'd0, exp});
            end
            checkOutput("burst_no_bubble", 16'(last_idx - first_idx), 16'd15);
        end

        // Reset while requester 1 holds the grant and a word is pending.
        doReset();
        v1 = 1; d1 = 8'h55; v0 = 0; yr = 1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pre_s",  {15'd0, s},  16'd1);
        checkOutput("rst_pre_yv", {15'd0, yv}, 16'd1);
        reset = 1; v0 = 1; d0 = 8'h66;
        @(posedge clk);
        #1;
        checkOutput("rst_yv", {15'd0, yv}, 16'd0);
        checkOutput("rst_y",  {8'd0, y},   16'd0);
        checkOutput("rst_s",  {15'd0, s},  16'd0);
        checkOutput("rst_r0", {15'd0, r0}, 16'd0);
        checkOutput("rst_r1", {15'd0, r1}, 16'd0);
        reset = 0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_s",  {15'd0, s},  16'd0);
        checkOutput("post_rst_r0", {15'd0, r0}, 16'd1);
        checkOutput("post_rst_r1", {15'd0, r1}, 16'd0);

        // MAXBURST=1 with downstream ready toggling: strict alternation.
        begin
            logic [7:0] got[$];
            int         i0, i1;
            logic       take0, take1;
            doReset();
            v0 = 0; v1 = 0;
            i0 = 0; i1 = 0;
            v0b = 1; v1b = 1; yrb = 1;
            for (int cyc = 0; cyc < 80 && got.size() < 8; cyc++) begin
                d0b = 8'(8'h10 + i0);
                d1b = 8'(8'h90 + i1);
                yrb = cyc[0];
                #1;
                take0 = r0b;
                take1 = r1b;
                if (yvb && yrb) got.push_back(yb);
                @(posedge clk);
                #1;
                if (take0) i0++;
                if (take1) i1++;
            end
            checkOutput("alt_count", 16'(got.size()), 16'd8);
            foreach (got[k]) begin
                logic [7:0] exp;
                exp = (k % 2 == 0) ? 8'(8'h10 + k / 2) : 8'(8'h90 + k / 2);
                checkOutput($sformatf("alt_word%0d", k), {8'd0, got[k]}, {8'd0, exp});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
